// File: rtl/c_bus_demux.sv
// c_bus_demux: one-entry write buffer that routes C-bus write-back data into R1..R14, TOTR and I
//
// Ports:
//   Clock, Resetn        rising-edge clock, asynchronous active-low reset
//   C_BUS_in [DATA_W]    write-back data
//   MUX1S [2]            destination source: 1 = RG1_out, 2 = MUX1D_out, 0/3 = none
//   RG1_out [DEST_W]     instruction-field destination code
//   MUX1D_out [DEST_W]   microcode destination code
//   WR_valid / WR_ready  write request handshake
//   HOLD                 stalls the commit stage
//   INC_TOTR             increments TOTR by one (a same-cycle commit to TOTR wins)
//   R1_out..R14_out      general registers
//   TOTR_out, I_out      total register, i register
//   WR_done              one-cycle pulse after a register write commits
//   BAD_dest             one-cycle pulse after a request with no legal destination
module c_bus_demux #(
  parameter int DATA_W = 16,
  parameter int DEST_W = 5
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [DATA_W-1:0] C_BUS_in,
  input  logic [1:0]        MUX1S,
  input  logic [DEST_W-1:0] RG1_out,
  input  logic [DEST_W-1:0] MUX1D_out,
  input  logic              WR_valid,
  output logic              WR_ready,
  input  logic              HOLD,
  input  logic              INC_TOTR,
  output logic [DATA_W-1:0] R1_out,
  output logic [DATA_W-1:0] R2_out,
  output logic [DATA_W-1:0] R3_out,
  output logic [DATA_W-1:0] R4_out,
  output logic [DATA_W-1:0] R5_out,
  output logic [DATA_W-1:0] R6_out,
  output logic [DATA_W-1:0] R7_out,
  output logic [DATA_W-1:0] R8_out,
  output logic [DATA_W-1:0] R9_out,
  output logic [DATA_W-1:0] R10_out,
  output logic [DATA_W-1:0] R11_out,
  output logic [DATA_W-1:0] R12_out,
  output logic [DATA_W-1:0] R13_out,
  output logic [DATA_W-1:0] R14_out,
  output logic [DATA_W-1:0] TOTR_out,
  output logic [DATA_W-1:0] I_out,
  output logic              WR_done,
  output logic              BAD_dest
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [DEST_W-1:0] buf_dest_q, buf_dest_d;
  logic [DATA_W-1:0] r_q [1:14];
  logic [DATA_W-1:0] r_d [1:14];
  logic [DATA_W-1:0] totr_q, totr_d, i_q, i_d;
  logic              wr_done_q, wr_done_d, bad_dest_q, bad_dest_d;
  logic              sel_ok, accept, load, commit, legal;
  always_comb begin
    sel_ok     = MUX1S == 2'd1 || MUX1S == 2'd2;
    WR_ready   = state_q == EMPTY || !HOLD;
    accept     = WR_valid && WR_ready;
    load       = accept && sel_ok;
    commit     = state_q == FULL && !HOLD;
    legal      = (buf_dest_q >= DEST_W'(1) && buf_dest_q <= DEST_W'(15)) || buf_dest_q == DEST_W'(23);
    // a new load keeps the buffer full even while the old entry commits
    state_d    = load ? FULL : commit ? EMPTY : state_q;
    buf_data_d = load ? C_BUS_in : buf_data_q;
    buf_dest_d = load ? (MUX1S == 2'd1 ? RG1_out : MUX1D_out) : buf_dest_q;
    for (int n = 1; n <= 14; n++)
      r_d[n] = commit && buf_dest_q == DEST_W'(n) ? buf_data_q : r_q[n];
    // a commit to TOTR overrides a simultaneous increment
    totr_d     = commit && buf_dest_q == DEST_W'(15) ? buf_data_q :
                 INC_TOTR ? totr_q + DATA_W'(1) : totr_q;
    i_d        = commit && buf_dest_q == DEST_W'(23) ? buf_data_q : i_q;
    wr_done_d  = commit && legal;
    bad_dest_d = (commit && !legal) || (accept && !sel_ok);
  end
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= EMPTY;
      buf_data_q <= '0;
      buf_dest_q <= '0;
      for (int n = 1; n <= 14; n++) r_q[n] <= '0;
      totr_q     <= '0;
      i_q        <= '0;
      wr_done_q  <= 1'b0;
      bad_dest_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_data_q <= buf_data_d;
      buf_dest_q <= buf_dest_d;
      r_q        <= r_d;
      totr_q     <= totr_d;
      i_q        <= i_d;
      wr_done_q  <= wr_done_d;
      bad_dest_q <= bad_dest_d;
    end
  end
  assign R1_out   = r_q[1];
  assign R2_out   = r_q[2];
  assign R3_out   = r_q[3];
  assign R4_out   = r_q[4];
  assign R5_out   = r_q[5];
  assign R6_out   = r_q[6];
  assign R7_out   = r_q[7];
  assign R8_out   = r_q[8];
  assign R9_out   = r_q[9];
  assign R10_out  = r_q[10];
  assign R11_out  = r_q[11];
  assign R12_out  = r_q[12];
  assign R13_out  = r_q[13];
  assign R14_out  = r_q[14];
  assign TOTR_out = totr_q;
  assign I_out    = i_q;
  assign WR_done  = wr_done_q;
  assign BAD_dest = bad_dest_q;
endmodule

// File: tb/tb_c_bus_demux.sv
// tb_c_bus_demux: scoreboard bench for c_bus_demux
module tb_c_bus_demux;
  logic        clk = 0, rst_n = 1;
  logic [15:0] c_bus = 0;
  logic [1:0]  mux1s = 0;
  logic [4:0]  rg1 = 0, mux1d = 0;
  logic        wr_valid = 0, hold = 0, inc_totr = 0;
  logic        wr_ready, wr_done, bad_dest;
  logic [15:0] r_out [1:14];
  logic [15:0] totr, i_out;
  typedef struct {logic [4:0] code; logic [15:0] data;} wr_t;
  wr_t         sb[$];
  wr_t         w;
  logic [15:0] exp_reg [0:31];
  int          vectors = 0, errors = 0;
  always #5 clk = ~clk;
  c_bus_demux dut (
    .Clock(clk), .Resetn(rst_n), .C_BUS_in(c_bus), .MUX1S(mux1s), .RG1_out(rg1), .MUX1D_out(mux1d),
    .WR_valid(wr_valid), .WR_ready(wr_ready), .HOLD(hold), .INC_TOTR(inc_totr),
    .R1_out(r_out[1]), .R2_out(r_out[2]), .R3_out(r_out[3]), .R4_out(r_out[4]), .R5_out(r_out[5]),
    .R6_out(r_out[6]), .R7_out(r_out[7]), .R8_out(r_out[8]), .R9_out(r_out[9]), .R10_out(r_out[10]),
    .R11_out(r_out[11]), .R12_out(r_out[12]), .R13_out(r_out[13]), .R14_out(r_out[14]),
    .TOTR_out(totr), .I_out(i_out), .WR_done(wr_done), .BAD_dest(bad_dest)
  );
  function automatic logic [15:0] dut_reg(input int c);
    logic [15:0] v;
    v = 16'h0;
    for (int n = 1; n <= 14; n++) if (n == c) v = r_out[n];
    if (c == 15) v = totr;
    if (c == 23) v = i_out;
    return v;
  endfunction
  function automatic int mism();
    int n = 0;
    for (int c = 1; c <= 23; c++) if ((c <= 15 || c == 23) && dut_reg(c) !== exp_reg[c]) n++;
    return n;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] s, input logic [4:0] code, input logic [15:0] d);
    wr_valid = 1; mux1s = s; c_bus = d;
    rg1   = s == 2'd2 ? ~code : code;
    mux1d = s == 2'd1 ? ~code : code;
    if (s == 2'd1 || s == 2'd2) sb.push_back('{code: code, data: d});
  endtask
  task automatic idle();
    wr_valid = 0; mux1s = 0;
  endtask
  task automatic test_reset();
    for (int c = 0; c < 32; c++) exp_reg[c] = 16'h0;
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (mism() !== 0) begin errors++; $display("FAIL reset_regs: %0d registers differ, want 0", mism()); end
    vectors++; if ({wr_done, bad_dest} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {wr_done, bad_dest}); end
    @(negedge clk) rst_n = 1;
    #1;
    vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
    step();
  endtask
  task automatic test_single();
    drive(2'd1, 5'd3, 16'h1234);
    vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", wr_ready); end
    step(); idle();
    vectors++; if (r_out[3] !== 16'h0) begin errors++; $display("FAIL single_early: R3 got %h want 0000", r_out[3]); end
    step();
    if (sb.size() == 0) begin vectors++; errors++; $display("FAIL single_sb: queue empty, want 1 entry"); end
    else begin
      w = sb.pop_front(); exp_reg[w.code] = w.data;
      vectors++; if (dut_reg(w.code) !== w.data) begin errors++; $display("FAIL single_data: code %0d got %h want %h", w.code, dut_reg(w.code), w.data); end
    end
    vectors++; if (wr_done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", wr_done); end
    vectors++; if (mism() !== 0) begin errors++; $display("FAIL single_others: %0d registers differ, want 0", mism()); end
    step();
    vectors++; if (wr_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", wr_done); end
  endtask
  task automatic test_back_to_back();
    drive(2'd2, 5'd15, 16'hAAAA);
    step();
    drive(2'd2, 5'd23, 16'h5555);
    vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_full: got %b want 1", wr_ready); end
    step(); idle();
    for (int k = 0; k < 2; k++) begin
      if (sb.size() == 0) begin vectors++; errors++; $display("FAIL b2b_sb: queue empty at commit %0d", k); end
      else begin
        w = sb.pop_front(); exp_reg[w.code] = w.data;
        vectors++; if (dut_reg(w.code) !== w.data) begin errors++; $display("FAIL b2b_data: code %0d got %h want %h", w.code, dut_reg(w.code), w.data); end
      end
      vectors++; if (wr_done !== 1'b1) begin errors++; $display("FAIL b2b_done: commit %0d got %b want 1", k, wr_done); end
      vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", wr_ready); end
      step();
    end
    vectors++; if ({wr_done, mism() == 0} !== 2'b01) begin errors++; $display("FAIL b2b_end: done %b mism %0d want 0/0", wr_done, mism()); end
  endtask
  task automatic test_hold();
    drive(2'd1, 5'd7, 16'h0F0F);
    hold = 1;
    step(); idle();
    for (int k = 0; k < 3; k++) begin
      vectors++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL hold_ready: cycle %0d got %b want 0", k, wr_ready); end
      vectors++; if (r_out[7] !== exp_reg[7] || wr_done !== 1'b0) begin errors++; $display("FAIL hold_r7: cycle %0d got %h/%b want %h/0", k, r_out[7], wr_done, exp_reg[7]); end
      step();
    end
    hold = 0;
    #1;
    vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b want 1", wr_ready); end
    step();
    if (sb.size() == 0) begin vectors++; errors++; $display("FAIL hold_sb: queue empty"); end
    else begin
      w = sb.pop_front(); exp_reg[w.code] = w.data;
      vectors++; if (dut_reg(w.code) !== w.data) begin errors++; $display("FAIL hold_data: code %0d got %h want %h", w.code, dut_reg(w.code), w.data); end
    end
    vectors++; if (wr_done !== 1'b1) begin errors++; $display("FAIL hold_done: got %b want 1", wr_done); end
    step();
  endtask
  task automatic test_totr();
    drive(2'd2, 5'd15, 16'hFFFF);
    step(); idle(); step();
    if (sb.size() == 0) begin vectors++; errors++; $display("FAIL totr_sb: queue empty"); end
    else begin
      w = sb.pop_front(); exp_reg[w.code] = w.data;
      vectors++; if (totr !== w.data) begin errors++; $display("FAIL totr_load: got %h want %h", totr, w.data); end
    end
    inc_totr = 1;
    step(); exp_reg[15] = 16'h0000;
    vectors++; if (totr !== exp_reg[15]) begin errors++; $display("FAIL totr_wrap: got %h want %h", totr, exp_reg[15]); end
    step(); exp_reg[15] = 16'h0001;
    vectors++; if (totr !== exp_reg[15]) begin errors++; $display("FAIL totr_inc: got %h want %h", totr, exp_reg[15]); end
    inc_totr = 0;
    drive(2'd2, 5'd15, 16'h0042);
    step(); idle();
    inc_totr = 1;
    step();
    inc_totr = 0;
    if (sb.size() == 0) begin vectors++; errors++; $display("FAIL totr_sb2: queue empty"); end
    else begin
      w = sb.pop_front(); exp_reg[w.code] = w.data;
      vectors++; if (totr !== w.data) begin errors++; $display("FAIL totr_commit_wins: got %h want %h", totr, w.data); end
    end
    step();
    vectors++; if (mism() !== 0) begin errors++; $display("FAIL totr_after: %0d registers differ", mism()); end
  endtask
  task automatic test_bad();
    int sels [6] = '{1, 2, 1, 2, 0, 3};
    int codes [6] = '{0, 16, 20, 31, 5, 9};
    for (int k = 0; k < 6; k++) begin
      drive(2'(sels[k]), 5'(codes[k]), 16'hDEA0 + 16'(k));
      step(); idle();
      if (sels[k] == 1 || sels[k] == 2) begin
        vectors++; if (bad_dest !== 1'b0) begin errors++; $display("FAIL bad_early: case %0d got %b want 0", k, bad_dest); end
        step();
        if (sb.size() != 0) w = sb.pop_front();
      end else begin
        hold = 1;
        #1;
        vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL bad_empty: case %0d ready got %b want 1", k, wr_ready); end
        hold = 0;
      end
      vectors++; if ({bad_dest, wr_done} !== 2'b10) begin errors++; $display("FAIL bad_pulse: case %0d bad/done got %b want 10", k, {bad_dest, wr_done}); end
      vectors++; if (mism() !== 0) begin errors++; $display("FAIL bad_regs: case %0d %0d registers differ", k, mism()); end
      step();
      vectors++; if (bad_dest !== 1'b0) begin errors++; $display("FAIL bad_width: case %0d got %b want 0", k, bad_dest); end
    end
  endtask
  task automatic test_stream();
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) begin
        int r = $urandom_range(0, 15);
        drive(2'($urandom_range(1, 2)), r == 0 ? 5'd23 : 5'(r), 16'($urandom));
        vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: beat %0d got %b want 1", k, wr_ready); end
      end else idle();
      step();
      if (k > 0) begin
        if (sb.size() == 0) begin vectors++; errors++; $display("FAIL stream_sb: beat %0d queue empty", k); end
        else begin
          w = sb.pop_front(); exp_reg[w.code] = w.data;
          vectors++; if (dut_reg(w.code) !== w.data || wr_done !== 1'b1) begin errors++; $display("FAIL stream_data: beat %0d code %0d got %h/%b want %h/1", k, w.code, dut_reg(w.code), wr_done, w.data); end
        end
        vectors++; if (mism() !== 0) begin errors++; $display("FAIL stream_regs: beat %0d %0d registers differ", k, mism()); end
      end
    end
    idle();
    step();
  endtask
  task automatic test_reset_full();
    drive(2'd1, 5'd5, 16'hBEEF);
    hold = 1;
    step(); idle();
    vectors++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rstfull_ready: got %b want 0", wr_ready); end
    #2 rst_n = 0;
    #1;
    sb.delete();
    for (int c = 0; c < 32; c++) exp_reg[c] = 16'h0;
    vectors++; if (mism() !== 0) begin errors++; $display("FAIL rstfull_clear: %0d registers differ, want 0", mism()); end
    vectors++; if ({wr_done, bad_dest} !== 2'b00) begin errors++; $display("FAIL rstfull_pulses: got %b want 00", {wr_done, bad_dest}); end
    hold = 0;
    step(); step();
    @(negedge clk) rst_n = 1;
    #1;
    vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rstfull_ready_release: got %b want 1", wr_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++; if (r_out[5] !== 16'h0 || wr_done !== 1'b0 || mism() !== 0) begin errors++; $display("FAIL rstfull_no_commit: cycle %0d R5 %h done %b want 0000/0", k, r_out[5], wr_done); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_totr();
    test_bad();
    test_stream();
    test_reset_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
